// File: rtl/imem_loader_if.sv
// Byte-stream handshake between a boot source and the loader.
// A byte moves when in_valid && in_ready at a rising edge.
interface imem_loader_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready
  );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction-memory writer: count, big-endian words, XOR csum.
// Holds the core stalled until the image is written and verified.
module imem_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  imem_loader_if.slave          src,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_run,
  output logic                  done,
  output logic                  error,
  output logic [15:0]           words_loaded
);

  typedef enum logic [2:0] {
    HDR_HI,
    HDR_LO,
    DATA,
    CSUM,
    DONE,
    ERROR
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] BASE =
    ADDR_WIDTH'(BASE_ADDR);
  localparam logic [16:0] MAX_N = 17'(1) << ADDR_WIDTH;

  state_t                state;
  logic [7:0]            n_hi;
  logic [15:0]           n_words;
  logic [23:0]           shreg;
  logic [1:0]            bcnt;
  logic [15:0]           wcnt;
  logic [7:0]            csum;
  logic [ADDR_WIDTH-1:0] waddr;
  logic                  hs;
  logic [15:0]           n_full;

  // Ready is low in the terminal states and while reset is held.
  assign src.in_ready = reset_n &&
    (state == HDR_HI || state == HDR_LO ||
     state == DATA   || state == CSUM);

  assign hs     = src.in_valid && src.in_ready;
  assign n_full = {n_hi, src.in_data};

  // Stream parser, word assembly, memory write and status registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= HDR_HI;
      n_hi         <= '0;
      n_words      <= '0;
      shreg        <= '0;
      bcnt         <= '0;
      wcnt         <= '0;
      csum         <= '0;
      waddr        <= BASE;
      imem_we      <= 1'b0;
      imem_addr    <= BASE;
      imem_wdata   <= '0;
      cpu_run      <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
    end else begin
      imem_we <= 1'b0;
      if (imem_we && words_loaded != 16'hFFFF)
        words_loaded <= words_loaded + 16'd1;
      if (hs) begin
        case (state)
          HDR_HI: begin
            n_hi  <= src.in_data;
            state <= HDR_LO;
          end
          HDR_LO: begin
            n_words <= n_full;
            if ({1'b0, n_full} > MAX_N) begin
              state <= ERROR;
              error <= 1'b1;
            end else if (n_full == 16'd0) begin
              state <= CSUM;
            end else begin
              state <= DATA;
            end
          end
          DATA: begin
            csum  <= csum ^ src.in_data;
            bcnt  <= bcnt + 2'd1;
            shreg <= {shreg[15:0], src.in_data};
            if (bcnt == 2'd3) begin
              imem_we    <= 1'b1;
              imem_wdata <= {shreg, src.in_data};
              imem_addr  <= waddr;
              waddr      <= waddr + 1'b1;
              wcnt       <= wcnt + 16'd1;
              if (wcnt == n_words - 16'd1)
                state <= CSUM;
            end
          end
          CSUM: begin
            if (src.in_data == csum) begin
              state   <= DONE;
              done    <= 1'b1;
              cpu_run <= 1'b1;
            end else begin
              state <= ERROR;
              error <= 1'b1;
            end
          end
          default: begin
            state <= state;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: scoreboard of expected memory writes
// plus status checks after each stream.
module tb_imem_loader;

  localparam int AW = 4;

  logic          clk;
  logic          reset_n;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_run;
  logic          done;
  logic          error;
  logic [15:0]   words_loaded;

  imem_loader_if bus ();

  imem_loader #(
    .ADDR_WIDTH(AW),
    .BASE_ADDR (0)
  ) u_dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .src         (bus),
    .imem_we     (imem_we),
    .imem_addr   (imem_addr),
    .imem_wdata  (imem_wdata),
    .cpu_run     (cpu_run),
    .done        (done),
    .error       (error),
    .words_loaded(words_loaded)
  );

  int n_cmp;
  int n_bad;
  int we_cnt;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Scoreboard: every write strobe must match the oldest expectation.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      we_cnt++;
      if (exp_q.size() == 0) begin
        check("wr_unexpected", {28'd0, imem_addr}, 32'hFFFF_FFFF);
      end else begin
        wr_t w;
        w = exp_q.pop_front();
        check("wr_addr", {28'd0, imem_addr}, w.addr);
        check("wr_data", imem_wdata, w.data);
      end
    end
  end

  task automatic push_wr(input int a, input logic [31:0] d);
    wr_t w;
    w.addr = 32'(a);
    w.data = d;
    exp_q.push_back(w);
  endtask

  task automatic put(input logic [7:0] b, input bit gap);
    if (gap) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_data  = 8'hA5 ^ b;
    end
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    check("rdy", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.in_valid = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic nominal(input logic [7:0] cs, input bit gap);
    logic [7:0] s [11];
    s = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
          8'h20, 8'h09, 8'hFE, 8'hFE, 8'h04};
    s[10] = cs;
    push_wr(0, 32'h2008_0005);
    push_wr(1, 32'h2009_FEFE);
    for (int i = 0; i < 11; i++) put(s[i], gap);
    idle();
  endtask

  task automatic check_status(input string tag,
                              input bit d, input bit e,
                              input int wl);
    check({tag, "_done"},  {31'd0, done},    {31'd0, d});
    check({tag, "_run"},   {31'd0, cpu_run}, {31'd0, d});
    check({tag, "_err"},   {31'd0, error},   {31'd0, e});
    check({tag, "_rdy"},   {31'd0, bus.in_ready}, 32'd0);
    check({tag, "_wl"},    {16'd0, words_loaded}, 32'(wl));
    check({tag, "_q"},     32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rdy"},  {31'd0, bus.in_ready}, 32'd0);
    check({tag, "_we"},   {31'd0, imem_we}, 32'd0);
    check({tag, "_addr"}, {28'd0, imem_addr}, 32'd0);
    check({tag, "_wd"},   imem_wdata, 32'd0);
    check({tag, "_run"},  {31'd0, cpu_run}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_err"},  {31'd0, error}, 32'd0);
    check({tag, "_wl"},   {16'd0, words_loaded}, 32'd0);
  endtask

  initial begin
    int w0;
    logic [7:0] b;
    logic [7:0] cs;
    logic [31:0] wd;

    n_cmp        = 0;
    n_bad        = 0;
    we_cnt       = 0;
    reset_n      = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;

    repeat (2) @(negedge clk);
    check_reset_vals("rst");
    reset_n = 1'b1;

    // nominal two-word image
    nominal(8'h04, 1'b0);
    check_status("nom", 1'b1, 1'b0, 2);

    // empty image, good and bad checksum
    do_reset();
    w0 = we_cnt;
    put(8'h00, 1'b0); put(8'h00, 1'b0); put(8'h00, 1'b0);
    idle();
    check_status("empty", 1'b1, 1'b0, 0);
    check("empty_we", 32'(we_cnt - w0), 32'd0);

    do_reset();
    put(8'h00, 1'b0); put(8'h00, 1'b0); put(8'h01, 1'b0);
    idle();
    check_status("empty_bad", 1'b0, 1'b1, 0);

    // bad checksum, then junk that must be ignored
    do_reset();
    nominal(8'h05, 1'b0);
    check_status("badcs", 1'b0, 1'b1, 2);
    w0 = we_cnt;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = 8'(i * 17);
    end
    idle();
    check("badcs_junk_we", 32'(we_cnt - w0), 32'd0);
    check_status("badcs2", 1'b0, 1'b1, 2);

    // oversize count: 17 words with a 16-word memory
    do_reset();
    w0 = we_cnt;
    put(8'h00, 1'b0); put(8'h11, 1'b0);
    idle();
    check("over_err", {31'd0, error}, 32'd1);
    repeat (3) @(negedge clk);
    check_status("over", 1'b0, 1'b1, 0);
    check("over_we", 32'(we_cnt - w0), 32'd0);

    // exactly full memory: 16 words
    do_reset();
    cs = 8'h00;
    put(8'h00, 1'b0); put(8'h10, 1'b0);
    for (int i = 0; i < 16; i++) begin
      wd = '0;
      for (int k = 0; k < 4; k++) begin
        b  = 8'((i * 4 + k) * 37 + 11);
        wd = {wd[23:0], b};
        cs = cs ^ b;
      end
      push_wr(i, wd);
      for (int k = 3; k >= 0; k--) put(wd[k*8 +: 8], 1'b0);
    end
    put(cs, 1'b0);
    idle();
    check_status("full", 1'b1, 1'b0, 16);

    // throttled source with junk on idle cycles
    do_reset();
    nominal(8'h04, 1'b1);
    check_status("thr", 1'b1, 1'b0, 2);

    // asynchronous reset mid-load, then a clean reload
    do_reset();
    put(8'h00, 1'b0); put(8'h02, 1'b0);
    put(8'h20, 1'b0); put(8'h08, 1'b0);
    put(8'h00, 1'b0); put(8'h05, 1'b0);
    #2;
    reset_n = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    check_reset_vals("midrst");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    nominal(8'h04, 1'b0);
    check_status("reload", 1'b1, 1'b0, 2);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
